// File: rtl/memory_pkg.sv
// Shared widths and FSM state encoding for the Hack data-memory front end.
package memory_pkg;

   localparam int unsigned HACK_DATA_WIDTH    = 16;
   localparam int unsigned RAM32K_ADDR_WIDTH  = 15;
   localparam int unsigned SPRAM_READ_LATENCY = 2;

   typedef enum logic [1:0] {
      ST_CLEAR     = 2'd0,
      ST_IDLE      = 2'd1,
      ST_READ_WAIT = 2'd2
   } port_state_e;

endpackage

// File: rtl/mem_clear_sequencer.sv
// Walks every RAM word address once after reset so the top can zero-fill the SPRAM.
module mem_clear_sequencer #(
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   output logic [ADDR_WIDTH-1:0] seq_address,
   output logic                  seq_load,
   output logic                  done
);

   // Extra top bit flags completion instead of wrapping back to address 0.
   logic [ADDR_WIDTH:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (enable && !count_q[ADDR_WIDTH]) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign seq_address = count_q[ADDR_WIDTH-1:0];
   assign done        = count_q[ADDR_WIDTH];
   assign seq_load    = enable && !count_q[ADDR_WIDTH];

endmodule

// File: rtl/ram_request_port.sv
// Valid/ready request port in front of ram32k: hides the registered read latency and
// optionally zero-fills the RAM after reset.
module ram_request_port
   import memory_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = RAM32K_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = HACK_DATA_WIDTH,
   parameter int unsigned READ_LATENCY   = SPRAM_READ_LATENCY,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  mem_load,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_in,
   input  logic [DATA_WIDTH-1:0] mem_out
);

   localparam int unsigned WaitW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

   port_state_e           state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  init_done_q, init_done_d;
   logic                  mem_load_q, mem_load_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_in_q, mem_in_d;
   logic [WaitW-1:0]      wait_q, wait_d;

   logic                  seq_enable;
   logic [ADDR_WIDTH-1:0] seq_address;
   logic                  seq_load;
   logic                  seq_done;
   logic                  clear_finished;

   assign seq_enable     = (state_q == ST_CLEAR);
   assign clear_finished = (CLEAR_ON_RESET == 0) || seq_done;

   mem_clear_sequencer #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clock       (clock),
      .reset       (reset),
      .enable      (seq_enable),
      .seq_address (seq_address),
      .seq_load    (seq_load),
      .done        (seq_done)
   );

   always_comb begin
      state_d       = state_q;
      req_ready_d   = req_ready_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      init_done_d   = init_done_q;
      mem_load_d    = 1'b0;
      mem_address_d = mem_address_q;
      mem_in_d      = mem_in_q;
      wait_d        = wait_q;

      case (state_q)
         ST_CLEAR: begin
            if (clear_finished) begin
               init_done_d = 1'b1;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               mem_load_d    = seq_load;
               mem_address_d = seq_address;
               mem_in_d      = '0;
            end
         end
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               mem_address_d = req_address;
               if (req_write) begin
                  mem_load_d = 1'b1;
                  mem_in_d   = req_wdata;
               end else begin
                  req_ready_d = 1'b0;
                  wait_d      = '0;
                  state_d     = ST_READ_WAIT;
               end
            end
         end
         ST_READ_WAIT: begin
            // One edge for the RAM to sample the address, then READ_LATENCY more.
            if (wait_q == WaitW'(READ_LATENCY)) begin
               rsp_rdata_d = mem_out;
               rsp_valid_d = 1'b1;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_CLEAR;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         init_done_q   <= 1'b0;
         mem_load_q    <= 1'b0;
         mem_address_q <= '0;
         mem_in_q      <= '0;
         wait_q        <= '0;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         init_done_q   <= init_done_d;
         mem_load_q    <= mem_load_d;
         mem_address_q <= mem_address_d;
         mem_in_q      <= mem_in_d;
         wait_q        <= wait_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign init_done   = init_done_q;
   assign mem_load    = mem_load_q;
   assign mem_address = mem_address_q;
   assign mem_in      = mem_in_q;

endmodule

// File: tb/tb_ram_request_port.sv
// Scoreboard bench for ram_request_port with a behavioural two-stage registered RAM.
module tb_ram_request_port;

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 16;
   localparam int unsigned NWORDS = 1 << AW;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_address;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          init_done, mem_load;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_in, mem_out;

   always #5 clock = ~clock;

   ram_request_port #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .READ_LATENCY   (2),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .init_done   (init_done),
      .mem_load    (mem_load),
      .mem_address (mem_address),
      .mem_in      (mem_in),
      .mem_out     (mem_out)
   );

   // ram32k stand-in: address sampled at an edge, data on mem_out two edges later.
   logic [DW-1:0] ram [0:NWORDS-1];
   logic [DW-1:0] rd_stage;
   logic          preload_en = 1'b0;
   logic [AW-1:0] preload_addr;
   logic [DW-1:0] preload_data;

   always @(posedge clock) begin
      if (preload_en) ram[preload_addr] <= preload_data;
      else if (mem_load) ram[mem_address] <= mem_in;
      rd_stage <= ram[mem_address];
      mem_out  <= rd_stage;
   end

   int cyc = 0;
   int accepts = 0;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (req_valid && req_ready && !reset) accepts <= accepts + 1;
   end

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] ref_mem [0:NWORDS-1];
   int            total = 0;
   int            bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: each expected read response is due at a fixed cycle after its accept.
   always @(negedge clock) begin
      if (!reset) begin
         if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
            mon_e = exp_q.pop_front();
            check("rsp_valid on time", {31'd0, rsp_valid}, 32'd1);
            if (rsp_valid) check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_e.data});
         end else if (rsp_valid) begin
            check("unexpected rsp_valid", {31'd0, rsp_valid}, 32'd0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int   n;
      exp_t e;
      req_valid   = 1'b1;
      req_write   = w;
      req_address = a;
      req_wdata   = d;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         check("accept timeout", {31'd0, req_ready}, 32'd1);
      end else if (w) begin
         ref_mem[a] = d;
      end else begin
         e.data = ref_mem[a];
         e.due  = cyc + 4;
         exp_q.push_back(e);
      end
      @(negedge clock);
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int            n, errs, a0;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      reset       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_address = '0;
      req_wdata   = '0;
      for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;

      // Garbage in the RAM before the clear, including the planted 0xBEEF.
      @(negedge clock);
      preload_en   = 1'b1;
      preload_addr = 15'h1234;
      preload_data = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         preload_addr = 15'($urandom);
         preload_data = 16'($urandom) | 16'h0001;
      end
      @(negedge clock);
      preload_en = 1'b0;

      check("reset req_ready", {31'd0, req_ready}, 32'd0);
      check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      check("reset init_done", {31'd0, init_done}, 32'd0);
      check("reset mem_load", {31'd0, mem_load}, 32'd0);
      check("reset mem_address", {17'd0, mem_address}, 32'd0);
      check("reset mem_in", {16'd0, mem_in}, 32'd0);

      // A write held during the clear must be ignored.
      req_valid   = 1'b1;
      req_write   = 1'b1;
      req_address = 15'h0055;
      req_wdata   = 16'hDEAD;
      reset       = 1'b0;
      n    = 0;
      errs = 0;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clock);
         if (init_done) break;
         n++;
         if (req_ready) errs++;
      end
      req_valid = 1'b0;
      req_write = 1'b0;
      check("clear length", n, 32'd32768);
      check("req_ready low during clear", errs, 32'd0);
      check("init_done after clear", {31'd0, init_done}, 32'd1);
      check("req_ready after clear", {31'd0, req_ready}, 32'd1);
      check("accepts during clear", accepts, 32'd0);
      errs = 0;
      for (int i = 0; i < NWORDS; i++) if (ram[i] !== 16'h0000) errs++;
      check("nonzero words after clear", errs, 32'd0);

      send(1'b0, 15'h1234, 16'h0);
      drain();

      // Read-after-write, with req_ready low through the read wait.
      send(1'b1, 15'h0ABC, 16'h7777);
      send(1'b0, 15'h0ABC, 16'h0);
      for (int i = 0; i < 3; i++) begin
         check("req_ready in read wait", {31'd0, req_ready}, 32'd0);
         @(negedge clock);
      end
      check("req_ready after read", {31'd0, req_ready}, 32'd1);
      drain();

      // Addresses differing only in the top bit.
      send(1'b1, 15'h4ABC, 16'h4444);
      send(1'b1, 15'h0ABC, 16'h1111);
      send(1'b0, 15'h4ABC, 16'h0);
      send(1'b0, 15'h0ABC, 16'h0);
      drain();

      // req_valid held through the whole read wait: exactly one accept.
      a0          = accepts;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = 15'h0001;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      mon_e.data = ref_mem[15'h0001];
      mon_e.due  = cyc + 4;
      exp_q.push_back(mon_e);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("req_ready with held valid", {31'd0, req_ready}, 32'd0);
      end
      @(negedge clock);
      req_valid = 1'b0;
      check("single accept with held valid", accepts - a0, 32'd1);
      drain();

      for (int i = 0; i < 10; i++) begin
         send(1'b0, 15'h0ABC, 16'h0);
         send(1'b0, 15'h4ABC, 16'h0);
      end
      drain();

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: a = 15'h0ABC;
            1: a = 15'h4ABC;
            2: a = 15'($urandom_range(0, 7));
            default: a = 15'($urandom);
         endcase
         d = 16'($urandom);
         send(1'($urandom_range(0, 1)), a, d);
      end
      drain();

      // Reset one cycle after a read accept.
      send(1'b0, 15'h0ABC, 16'h0);
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mid-read reset mem_load", {31'd0, mem_load}, 32'd0);
      check("mid-read reset req_ready", {31'd0, req_ready}, 32'd0);
      check("mid-read reset init_done", {31'd0, init_done}, 32'd0);
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (rsp_valid) errs++;
      end
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (rsp_valid) errs++;
         check("restarted clear address", {17'd0, mem_address}, k);
         check("restarted clear mem_load", {31'd0, mem_load}, 32'd1);
      end
      check("no rsp after mid-read reset", errs, 32'd0);

      // Reset during the clear while mem_load is high.
      reset = 1'b1;
      #1;
      check("async mem_load drop", {31'd0, mem_load}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("clear restart address", {17'd0, mem_address}, 32'd0);
      check("clear restart mem_load", {31'd0, mem_load}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
